// File: rtl/alpha_blend_pipe_if.sv
// Pixel stream bundle for alpha_blend_pipe: input pixel pair with alpha/mode
// on a valid/ready handshake, and the blended result on a second handshake.
interface alpha_blend_pipe_if #(
    parameter int CH_W    = 8,
    parameter int NUM_CH  = 3,
    parameter int ALPHA_W = 8
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*CH_W-1:0]   fg_px;
    logic [NUM_CH*CH_W-1:0]   bg_px;
    logic [ALPHA_W-1:0]       alpha;
    logic [1:0]               mode;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*CH_W-1:0]   out_px;
    logic                     out_last;

    modport master (
        output in_valid, fg_px, bg_px, alpha, mode, in_last, out_ready,
        input  in_ready, out_valid, out_px, out_last
    );

    modport slave (
        input  in_valid, fg_px, bg_px, alpha, mode, in_last, out_ready,
        output in_ready, out_valid, out_px, out_last
    );
endinterface

// File: rtl/alpha_blend_pipe.sv
// Three-stage alpha blender, one pixel per clock; all stages share a single
// enable so a downstream stall freezes the whole pipe without losing pixels.
module alpha_blend_pipe #(
    parameter int CH_W      = 8,
    parameter int NUM_CH    = 3,
    parameter int ALPHA_W   = 8,
    parameter int ALPHA_MAX = 255
) (
    input  logic              clk,
    input  logic              n_rst,
    alpha_blend_pipe_if.slave bus,
    output logic              done,
    output logic              busy
);
    localparam int PX_W   = NUM_CH * CH_W;
    localparam int PROD_W = CH_W + ALPHA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic [ALPHA_W-1:0] A_MAX   = ALPHA_W'(ALPHA_MAX);
    localparam logic [SUM_W-1:0]   HALF    = SUM_W'(ALPHA_MAX / 2);
    localparam logic [SUM_W-1:0]   DIVISOR = SUM_W'(ALPHA_MAX);
    localparam logic [SUM_W-1:0]   CH_SAT  = SUM_W'((1 << CH_W) - 1);

    typedef enum logic [1:0] {
        MODE_BLEND = 2'd0,
        MODE_FG    = 2'd1,
        MODE_BG    = 2'd2,
        MODE_ADD   = 2'd3
    } mode_e;

    logic                 en;
    logic [ALPHA_W-1:0]   a_clamp;

    logic                 s1_v, s1_last;
    mode_e                s1_mode;
    logic [PX_W-1:0]      s1_fg, s1_bg;
    logic [ALPHA_W-1:0]   s1_a, s1_ia;

    logic                 s2_v, s2_last;
    mode_e                s2_mode;
    logic [PX_W-1:0]      s2_fg, s2_bg;
    logic [NUM_CH*PROD_W-1:0] s2_fga, s2_bgia;

    logic [PX_W-1:0]      next_px;

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign a_clamp      = (bus.alpha > A_MAX) ? A_MAX : bus.alpha;
    assign busy         = s1_v | s2_v | bus.out_valid;

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_v          <= 1'b0;
            s1_last       <= 1'b0;
            s1_mode       <= MODE_BLEND;
            s2_v          <= 1'b0;
            s2_last       <= 1'b0;
            s2_mode       <= MODE_BLEND;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_px    <= '0;
            done          <= 1'b0;
        end else begin
            done <= bus.out_valid && bus.out_ready && bus.out_last;
            if (en) begin
                s1_v          <= bus.in_valid;
                s1_last       <= bus.in_valid && bus.in_last;
                s1_mode       <= mode_e'(bus.mode);
                s2_v          <= s1_v;
                s2_last       <= s1_last;
                s2_mode       <= s1_mode;
                bus.out_valid <= s2_v;
                bus.out_last  <= s2_last;
                // Hold the last real result rather than loading bubble garbage.
                if (s2_v) bus.out_px <= next_px;
            end
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents matter.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_fg <= bus.fg_px;
            s1_bg <= bus.bg_px;
            s1_a  <= a_clamp;
            s1_ia <= A_MAX - a_clamp;
            s2_fg <= s1_fg;
            s2_bg <= s1_bg;
            for (int i = 0; i < NUM_CH; i++) begin
                s2_fga[i*PROD_W +: PROD_W]  <= PROD_W'(s1_fg[i*CH_W +: CH_W]) * PROD_W'(s1_a);
                s2_bgia[i*PROD_W +: PROD_W] <= PROD_W'(s1_bg[i*CH_W +: CH_W]) * PROD_W'(s1_ia);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CH_W-1:0]  fg_ch, bg_ch, blend_ch, res_ch;
        logic [SUM_W-1:0] fga, bgia, add_sum;

        assign fg_ch    = s2_fg[i*CH_W +: CH_W];
        assign bg_ch    = s2_bg[i*CH_W +: CH_W];
        assign fga      = SUM_W'(s2_fga[i*PROD_W +: PROD_W]);
        assign bgia     = SUM_W'(s2_bgia[i*PROD_W +: PROD_W]);
        // The weighted sum never exceeds ALPHA_MAX*(2^CH_W-1), so the quotient fits CH_W bits.
        assign blend_ch = CH_W'((fga + bgia + HALF) / DIVISOR);
        assign add_sum  = (fga + HALF) / DIVISOR + SUM_W'(bg_ch);

        // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
        always_comb begin
            res_ch = blend_ch;
            case (s2_mode)
                MODE_FG:  res_ch = fg_ch;
                MODE_BG:  res_ch = bg_ch;
                MODE_ADD: res_ch = (add_sum > CH_SAT) ? CH_SAT[CH_W-1:0] : add_sum[CH_W-1:0];
                default:  res_ch = blend_ch;
            endcase
        end

        assign next_px[i*CH_W +: CH_W] = res_ch;
    end
endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Directed bench for alpha_blend_pipe: scoreboard queue filled on input
// transfer and drained on output transfer, plus a decimal-alpha instance.
module tb_alpha_blend_pipe;
    typedef struct packed {
        logic        last;
        logic [23:0] px;
    } exp_t;

    logic clk;
    logic n_rst;
    logic done, busy;
    logic d_done, d_busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;
    int   n_done   = 0;
    int   n_stall  = 0;
    bit   prev_last_xfer = 1'b0;

    alpha_blend_pipe_if #(.CH_W(8), .NUM_CH(3), .ALPHA_W(8)) m_bus ();
    alpha_blend_pipe_if #(.CH_W(8), .NUM_CH(3), .ALPHA_W(4)) d_bus ();

    alpha_blend_pipe #(.CH_W(8), .NUM_CH(3), .ALPHA_W(8), .ALPHA_MAX(255)) u_dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (m_bus),
        .done (done),
        .busy (busy)
    );

    alpha_blend_pipe #(.CH_W(8), .NUM_CH(3), .ALPHA_W(4), .ALPHA_MAX(10)) u_dec (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (d_bus),
        .done (d_done),
        .busy (d_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference blend built straight from the arithmetic definition, 8-bit channels.
    function automatic logic [23:0] model(input logic [23:0] fg, input logic [23:0] bg,
                                          input int alpha, input int mode, input int amax);
        logic [23:0] res;
        int a, ia, f, b, r;
        a  = (alpha > amax) ? amax : alpha;
        ia = amax - a;
        res = '0;
        for (int c = 0; c < 3; c++) begin
            f = int'(fg[c*8 +: 8]);
            b = int'(bg[c*8 +: 8]);
            case (mode)
                0: r = (f * a + b * ia + amax / 2) / amax;
                1: r = f;
                2: r = b;
                default: begin
                    r = (f * a + amax / 2) / amax + b;
                    if (r > 255) r = 255;
                end
            endcase
            res[c*8 +: 8] = 8'(r);
        end
        return res;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [23:0] fg, input logic [23:0] bg, input int alpha,
                        input int mode, input bit last, input logic [23:0] exp_px);
        exp_t e;
        bit   ok;
        m_bus.fg_px    = fg;
        m_bus.bg_px    = bg;
        m_bus.alpha    = 8'(alpha);
        m_bus.mode     = 2'(mode);
        m_bus.in_last  = last;
        m_bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        e.last = last;
        e.px   = exp_px;
        sb.push_back(e);
        @(posedge clk);
        #1;
        m_bus.in_valid = 1'b0;
        m_bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic dec_px(input string tag, input logic [23:0] fg, input logic [23:0] bg,
                          input logic [3:0] a, input logic [23:0] exp_px);
        bit seen;
        d_bus.fg_px    = fg;
        d_bus.bg_px    = bg;
        d_bus.alpha    = a;
        d_bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        d_bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (d_bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
        if (seen) check(tag, 32'(d_bus.out_px), 32'(exp_px));
    endtask

    // Output monitor: scoreboard pop, handshake rule and done-pulse timing.
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_last_xfer = 1'b0;
        end else begin
            check("in_ready_rule", 32'(m_bus.in_ready), 32'(!(m_bus.out_valid && !m_bus.out_ready)));
            check("done_pulse", 32'(done), 32'(prev_last_xfer));
            if (done) n_done++;
            if (m_bus.out_valid && !m_bus.out_ready) n_stall++;
            prev_last_xfer = m_bus.out_valid && m_bus.out_ready && m_bus.out_last;
            if (m_bus.out_valid && m_bus.out_ready) begin
                exp_t e;
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(m_bus.out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_px", 32'(m_bus.out_px), 32'(e.px));
                    check("out_last", 32'(m_bus.out_last), 32'(e.last));
                end
            end
        end
    end

    initial begin
        int target, d0;
        logic [23:0] fg, bg;
        int alpha;

        n_rst = 1'b0;
        m_bus.in_valid = 1'b0; m_bus.fg_px = '0; m_bus.bg_px = '0; m_bus.alpha = '0;
        m_bus.mode = '0; m_bus.in_last = 1'b0; m_bus.out_ready = 1'b1;
        d_bus.in_valid = 1'b0; d_bus.fg_px = '0; d_bus.bg_px = '0; d_bus.alpha = '0;
        d_bus.mode = '0; d_bus.in_last = 1'b0; d_bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(m_bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_px", 32'(m_bus.out_px), 32'd0);
        check("rst_in_ready", 32'(m_bus.in_ready), 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Blend with latency probe: accepted on edge N, visible after N+2.
        send(24'hFF0000, 24'h0000FF, 128, 0, 1'b0, 24'h80007F);
        check("lat_n", 32'(m_bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_n1", 32'(m_bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_n2", 32'(m_bus.out_valid), 32'd1);
        check("lat_px", 32'(m_bus.out_px), 32'h80007F);
        drain();

        // Alpha bounds, saturating add, pass-through modes.
        send(24'h123456, 24'hABCDEF, 0,   0, 1'b0, 24'hABCDEF);
        send(24'h123456, 24'hABCDEF, 255, 0, 1'b0, 24'h123456);
        send(24'hC8C8C8, 24'h646464, 255, 3, 1'b0, 24'hFFFFFF);
        send(24'h101010, 24'h202020, 255, 3, 1'b0, 24'h303030);
        send(24'h3A7F01, 24'h99EE44, 77,  1, 1'b0, 24'h3A7F01);
        send(24'h3A7F01, 24'h99EE44, 77,  2, 1'b0, 24'h99EE44);
        for (int i = 0; i < 6; i++) begin
            fg = 24'($urandom);
            bg = 24'($urandom);
            alpha = int'($urandom_range(0, 255));
            send(fg, bg, alpha, i % 4, 1'b0, model(fg, bg, alpha, i % 4, 255));
        end
        drain();

        // Backpressure: 8 back-to-back pixels, 4-cycle stall after the 2nd output.
        target = n_out + 2;
        n_stall = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    fg = {8'(i * 30), 8'(i * 17 + 3), 8'(255 - i * 20)};
                    bg = 24'($urandom);
                    send(fg, bg, i * 33, i % 4, 1'b0, model(fg, bg, i * 33, i % 4, 255));
                end
            end
            begin
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk);
                    if (n_out >= target) break;
                end
                #1;
                m_bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                m_bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", 32'(n_stall), 32'd4);

        // Span end marking and done pulse.
        d0 = n_done;
        for (int i = 0; i < 4; i++) begin
            fg = 24'($urandom);
            bg = 24'($urandom);
            send(fg, bg, 200, 0, (i == 3), model(fg, bg, 200, 0, 255));
        end
        drain();
        check("busy_drained", 32'(busy), 32'd0);
        check("done_count", 32'(n_done - d0), 32'd1);

        // Asynchronous reset with three pixels in flight.
        send(24'h111111, 24'h0, 0, 1, 1'b0, 24'h111111);
        send(24'h222222, 24'h0, 0, 1, 1'b0, 24'h222222);
        send(24'h333333, 24'h0, 0, 1, 1'b1, 24'h333333);
        check("pre_rst_busy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(m_bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_out_px", 32'(m_bus.out_px), 32'd0);
        check("mid_rst_out_last", 32'(m_bus.out_last), 32'd0);
        check("mid_rst_in_ready", 32'(m_bus.in_ready), 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(m_bus.out_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        send(24'h0A0B0C, 24'hF0F0F0, 64, 0, 1'b0, model(24'h0A0B0C, 24'hF0F0F0, 64, 0, 255));
        drain();

        // Decimal-alpha instance: clamp and mid-range weight.
        dec_px("dec_clamp", 24'hC8C8C8, 24'h646464, 4'd15, 24'hC8C8C8);
        dec_px("dec_half",  24'hC8C8C8, 24'h646464, 4'd5,  24'h969696);
        repeat (4) @(posedge clk);
        #1;
        check("dec_busy_idle", 32'(d_busy), 32'd0);
        check("dec_done_idle", 32'(d_done), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
